// File: rtl/aes_mm_bridge_if.sv
// ============================================================================
// Module   : aes_mm_bridge_if
// Desc     : Bus-side and core-side signal bundle for the AES memory bridge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface aes_mm_bridge_if #(
  parameter int BUS_W = 32
);
  logic             iChipSelect_n;
  logic             iWrite_n;
  logic             iRead_n;
  logic [3:0]       iAddress;
  logic [BUS_W-1:0] iData;
  logic [BUS_W-1:0] oData;
  logic             oIrq;
  logic [127:0]     oCoreData;
  logic             oLoadData;
  logic             oLoadKey;
  logic             iCoreReady;
  logic             iCTValid;
  logic [127:0]     iCipherText;

  modport slave (
    input  iChipSelect_n, iWrite_n, iRead_n, iAddress, iData,
    input  iCoreReady, iCTValid, iCipherText,
    output oData, oIrq, oCoreData, oLoadData, oLoadKey
  );

  modport master (
    output iChipSelect_n, iWrite_n, iRead_n, iAddress, iData,
    output iCoreReady, iCTValid, iCipherText,
    input  oData, oIrq, oCoreData, oLoadData, oLoadKey
  );
endinterface

`default_nettype wire

// File: rtl/aes_mm_bridge.sv
// ============================================================================
// Module   : aes_mm_bridge
// Desc     : Memory-mapped front end for the AES-128 core with handshaked
//            loads, a ciphertext result FIFO, sticky flags and an interrupt.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_mm_bridge #(
  parameter int BUS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic           iClk,
  input  logic           iReset_n,
  aes_mm_bridge_if.slave bus
);

  localparam int WORDS = 128 / BUS_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;

  localparam logic [3:0] C_ADDR_CMD    = 4'h4;
  localparam logic [3:0] C_ADDR_STATUS = 4'h5;
  localparam logic [3:0] C_ADDR_IRQ_EN = 4'h6;
  localparam logic [3:0] C_ADDR_POP    = 4'hC;

  logic             w_wr, w_rd;
  logic             w_word_hit, w_word_wr, w_cmd_wr;
  logic             w_cmd_ok, w_cmd_err, w_word_err;
  logic             w_clear, w_clr_flags, w_issue;
  logic             w_empty, w_full, w_push, w_pop, w_ovf_evt;
  logic [127:0]     w_head;
  logic [BUS_W-1:0] w_in_word, w_head_word;
  logic [15:0]      w_status;

  logic [127:0]     core_data_q, core_data_d;
  logic             pending_q, pending_d;
  logic             key_q, key_d;
  logic             load_data_q, load_data_d;
  logic             load_key_q, load_key_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [2:0]       irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic [127:0]     mem_q [DEPTH];

  assign w_wr = ~bus.iChipSelect_n & ~bus.iWrite_n;
  assign w_rd = ~bus.iChipSelect_n & ~bus.iRead_n;

  // Word k maps to the k-th BUS_W slice counted from the MSB end.
  always_comb begin
    w_word_hit  = 1'b0;
    w_in_word   = '0;
    w_head_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (bus.iAddress[1:0] == 2'(k)) begin
        w_word_hit  = 1'b1;
        w_in_word   = core_data_q[127 - k*BUS_W -: BUS_W];
        w_head_word = w_head[127 - k*BUS_W -: BUS_W];
      end
    end
  end

  assign w_word_wr   = w_wr & (bus.iAddress[3:2] == 2'b00) & w_word_hit;
  assign w_cmd_wr    = w_wr & (bus.iAddress == C_ADDR_CMD);
  assign w_cmd_ok    = w_cmd_wr & (bus.iData[0] ^ bus.iData[1]) & ~pending_q;
  assign w_cmd_err   = w_cmd_wr & ((bus.iData[0] & bus.iData[1]) |
                                   (pending_q & (bus.iData[0] | bus.iData[1])));
  assign w_word_err  = w_word_wr & pending_q;
  assign w_clear     = w_cmd_wr & bus.iData[2];
  assign w_clr_flags = w_cmd_wr & bus.iData[3];
  assign w_issue     = pending_q & bus.iCoreReady;

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == CW'(DEPTH));
  assign w_pop     = w_wr & (bus.iAddress == C_ADDR_POP) & ~w_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_push    = bus.iCTValid & (~w_full | w_pop) & ~w_clear;
  assign w_ovf_evt = bus.iCTValid & w_full & ~w_pop & ~w_clear;
  assign w_head    = mem_q[rd_ptr_q];

  assign w_status = {8'(count_q), 2'b00, err_q, ovf_q, bus.iCoreReady,
                     pending_q, w_full, ~w_empty};

  always_comb begin
    core_data_d = core_data_q;
    pending_d   = pending_q;
    key_d       = key_q;
    load_data_d = w_issue & ~key_q;
    load_key_d  = w_issue & key_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    irq_en_d    = irq_en_q;
    rdata_d     = rdata_q;

    if (w_word_wr && !pending_q) begin
      for (int k = 0; k < WORDS; k++) begin
        if (bus.iAddress[1:0] == 2'(k)) begin
          core_data_d[127 - k*BUS_W -: BUS_W] = bus.iData;
        end
      end
    end

    if (w_cmd_ok) begin
      pending_d = 1'b1;
      key_d     = bus.iData[1];
    end else if (w_issue) begin
      pending_d = 1'b0;
    end

    if (w_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(w_push) - CW'(w_pop);
    end

    if (w_wr && bus.iAddress == C_ADDR_IRQ_EN) irq_en_d = bus.iData[2:0];

    if (w_rd) begin
      case (bus.iAddress)
        4'h0, 4'h1, 4'h2, 4'h3: rdata_d = w_in_word;
        C_ADDR_STATUS:          rdata_d = BUS_W'(w_status);
        C_ADDR_IRQ_EN:          rdata_d = BUS_W'(irq_en_q);
        4'h8, 4'h9, 4'hA, 4'hB: rdata_d = w_empty ? '0 : w_head_word;
        default:                rdata_d = '0;
      endcase
    end
  end

  // Set events beat CLR_FLAGS when they coincide.
  assign ovf_d = (ovf_q & ~w_clr_flags) | w_ovf_evt;
  assign err_d = (err_q & ~w_clr_flags) | w_cmd_err | w_word_err;
  assign irq_d = (irq_en_q[0] & ~w_empty) | (irq_en_q[1] & ovf_q) |
                 (irq_en_q[2] & err_q);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      core_data_q <= '0;
      pending_q   <= 1'b0;
      key_q       <= 1'b0;
      load_data_q <= 1'b0;
      load_key_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      irq_en_q    <= '0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      core_data_q <= core_data_d;
      pending_q   <= pending_d;
      key_q       <= key_d;
      load_data_q <= load_data_d;
      load_key_q  <= load_key_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge iClk) begin
    if (w_push) mem_q[wr_ptr_q] <= bus.iCipherText;
  end

  assign bus.oData     = rdata_q;
  assign bus.oIrq      = irq_q;
  assign bus.oCoreData = core_data_q;
  assign bus.oLoadData = load_data_q;
  assign bus.oLoadKey  = load_key_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_mm_bridge.sv
// ============================================================================
// Module   : tb_aes_mm_bridge
// Desc     : Self-checking bench for aes_mm_bridge (32- and 64-bit buses).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_mm_bridge;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_mm_bridge_if #(.BUS_W(32)) b32 ();
  aes_mm_bridge_if #(.BUS_W(64)) b64 ();

  aes_mm_bridge #(.BUS_W(32), .DEPTH(DEPTH)) u_dut32 (
    .iClk(clk), .iReset_n(rst_n), .bus(b32.slave));
  aes_mm_bridge #(.BUS_W(64), .DEPTH(DEPTH)) u_dut64 (
    .iClk(clk), .iReset_n(rst_n), .bus(b64.slave));

  int checks   = 0;
  int failures = 0;
  logic [127:0] sb32[$];
  logic [127:0] sb64[$];
  logic m_ovf32 = 1'b0;
  int ld_data_cnt = 0;
  int ld_key_cnt  = 0;

  always @(negedge clk) begin
    if (b32.oLoadData === 1'b1) ld_data_cnt++;
    if (b32.oLoadKey === 1'b1)  ld_key_cnt++;
  end

  function automatic logic [127:0] mk(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i), ~32'(i), 32'(i)};
  endfunction

  function automatic logic [31:0] exp_status32(input logic ovf, input logic ready);
    int n;
    n = sb32.size();
    return {16'h0, 8'(n), 2'b00, 1'b0, ovf, ready, 1'b0, n == DEPTH, n != 0};
  endfunction

  task automatic idle();
    b32.iChipSelect_n = 1; b32.iWrite_n = 1; b32.iRead_n = 1; b32.iAddress = 0;
    b32.iData = 0; b32.iCoreReady = 0; b32.iCTValid = 0; b32.iCipherText = 0;
    b64.iChipSelect_n = 1; b64.iWrite_n = 1; b64.iRead_n = 1; b64.iAddress = 0;
    b64.iData = 0; b64.iCoreReady = 0; b64.iCTValid = 0; b64.iCipherText = 0;
  endtask

  task automatic wr32(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    b32.iChipSelect_n = 0; b32.iWrite_n = 0; b32.iAddress = a; b32.iData = d;
    @(negedge clk);
    b32.iChipSelect_n = 1; b32.iWrite_n = 1;
  endtask

  task automatic rd32(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    b32.iChipSelect_n = 0; b32.iRead_n = 0; b32.iAddress = a;
    @(negedge clk);
    d = b32.oData;
    b32.iChipSelect_n = 1; b32.iRead_n = 1;
  endtask

  task automatic push32(input logic [127:0] v);
    @(negedge clk);
    b32.iCTValid = 1; b32.iCipherText = v;
    @(negedge clk);
    b32.iCTValid = 0;
    if (sb32.size() < DEPTH) sb32.push_back(v);
    else m_ovf32 = 1'b1;
  endtask

  task automatic head32(output logic [127:0] v);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      rd32(4'(8 + k), w);
      v[127 - k*32 -: 32] = w;
    end
  endtask

  task automatic wr64(input logic [3:0] a, input logic [63:0] d);
    @(negedge clk);
    b64.iChipSelect_n = 0; b64.iWrite_n = 0; b64.iAddress = a; b64.iData = d;
    @(negedge clk);
    b64.iChipSelect_n = 1; b64.iWrite_n = 1;
  endtask

  task automatic rd64(input logic [3:0] a, output logic [63:0] d);
    @(negedge clk);
    b64.iChipSelect_n = 0; b64.iRead_n = 0; b64.iAddress = a;
    @(negedge clk);
    d = b64.oData;
    b64.iChipSelect_n = 1; b64.iRead_n = 1;
  endtask

  task automatic test_reset();
    logic [31:0] s;
    checks++; if (b32.oData !== 32'h0) begin failures++; $display("FAIL reset_oData got=%h exp=0", b32.oData); end
    checks++; if (b32.oIrq !== 1'b0) begin failures++; $display("FAIL reset_oIrq got=%b exp=0", b32.oIrq); end
    checks++; if (b32.oCoreData !== 128'h0) begin failures++; $display("FAIL reset_oCoreData got=%h exp=0", b32.oCoreData); end
    checks++; if ({b32.oLoadData, b32.oLoadKey} !== 2'b00) begin failures++; $display("FAIL reset_loads got=%b exp=00", {b32.oLoadData, b32.oLoadKey}); end
    checks++; if ({b64.oData, b64.oIrq, b64.oLoadData, b64.oLoadKey} !== 67'h0) begin failures++; $display("FAIL reset_dut64 got=%h exp=0", {b64.oData, b64.oIrq, b64.oLoadData, b64.oLoadKey}); end
    rd32(4'h5, s);
    checks++; if (s !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", s); end
  endtask

  task automatic test_key_load();
    int k0;
    b32.iCoreReady = 1;
    wr32(4'h0, 32'h0011_2233);
    wr32(4'h1, 32'h4455_6677);
    wr32(4'h2, 32'h8899_AABB);
    wr32(4'h3, 32'hCCDD_EEFF);
    k0 = ld_key_cnt;
    @(negedge clk);
    b32.iChipSelect_n = 0; b32.iWrite_n = 0; b32.iAddress = 4'h4; b32.iData = 32'h2;
    @(negedge clk);
    b32.iChipSelect_n = 1; b32.iWrite_n = 1;
    checks++; if (b32.oLoadKey !== 1'b0) begin failures++; $display("FAIL key_early got=%b exp=0", b32.oLoadKey); end
    @(negedge clk);
    checks++; if ({b32.oLoadKey, b32.oLoadData} !== 2'b10) begin failures++; $display("FAIL key_pulse got=%b exp=10", {b32.oLoadKey, b32.oLoadData}); end
    checks++; if (b32.oCoreData !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin failures++; $display("FAIL key_data got=%h exp=00112233445566778899aabbccddeeff", b32.oCoreData); end
    @(negedge clk);
    checks++; if (b32.oLoadKey !== 1'b0) begin failures++; $display("FAIL key_fall got=%b exp=0", b32.oLoadKey); end
    repeat (3) @(negedge clk);
    checks++; if (ld_key_cnt - k0 !== 1) begin failures++; $display("FAIL key_count got=%0d exp=1", ld_key_cnt - k0); end
  endtask

  task automatic test_pending_err();
    logic [31:0] s;
    int d0;
    b32.iCoreReady = 0;
    d0 = ld_data_cnt;
    wr32(4'h4, 32'h1);
    rd32(4'h5, s);
    checks++; if (s !== 32'h04) begin failures++; $display("FAIL pend_status got=%h exp=04", s); end
    wr32(4'h4, 32'h1);
    wr32(4'h0, 32'hDEAD_BEEF);
    rd32(4'h5, s);
    checks++; if (s !== 32'h24) begin failures++; $display("FAIL pend_err got=%h exp=24", s); end
    checks++; if (b32.oCoreData !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin failures++; $display("FAIL pend_hold got=%h", b32.oCoreData); end
    checks++; if (ld_data_cnt !== d0) begin failures++; $display("FAIL pend_nopulse got=%0d exp=%0d", ld_data_cnt, d0); end
    @(negedge clk);
    b32.iCoreReady = 1;
    repeat (4) @(negedge clk);
    checks++; if (ld_data_cnt - d0 !== 1) begin failures++; $display("FAIL pend_pulse got=%0d exp=1", ld_data_cnt - d0); end
    rd32(4'h5, s);
    checks++; if (s !== 32'h28) begin failures++; $display("FAIL pend_clear got=%h exp=28", s); end
    wr32(4'h4, 32'h8);
    rd32(4'h5, s);
    checks++; if (s !== 32'h08) begin failures++; $display("FAIL clr_flags got=%h exp=08", s); end
    wr32(4'h4, 32'hB);
    rd32(4'h5, s);
    checks++; if (s !== 32'h28) begin failures++; $display("FAIL set_wins got=%h exp=28", s); end
    wr32(4'h4, 32'h8);
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] s;
    logic [127:0] v, e;
    for (int i = 1; i <= 5; i++) push32(mk(i));
    rd32(4'h5, s);
    checks++; if (s !== exp_status32(m_ovf32, 1'b1)) begin failures++; $display("FAIL ovf_status got=%h exp=%h", s, exp_status32(m_ovf32, 1'b1)); end
    for (int i = 0; i < 4; i++) begin
      head32(v);
      e = sb32.pop_front();
      checks++; if (v !== e) begin failures++; $display("FAIL fifo_head%0d got=%h exp=%h", i, v, e); end
      wr32(4'hC, 32'h0);
    end
    head32(v);
    checks++; if (v !== 128'h0) begin failures++; $display("FAIL fifo_empty_read got=%h exp=0", v); end
    wr32(4'hC, 32'h0);
    rd32(4'h5, s);
    checks++; if (s !== exp_status32(m_ovf32, 1'b1)) begin failures++; $display("FAIL empty_pop got=%h exp=%h", s, exp_status32(m_ovf32, 1'b1)); end
    wr32(4'h4, 32'h8);
    m_ovf32 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    logic [127:0] v, e;
    for (int i = 11; i <= 14; i++) push32(mk(i));
    @(negedge clk);
    b32.iChipSelect_n = 0; b32.iWrite_n = 0; b32.iAddress = 4'hC;
    b32.iCTValid = 1; b32.iCipherText = mk(15);
    @(negedge clk);
    b32.iChipSelect_n = 1; b32.iWrite_n = 1; b32.iCTValid = 0;
    void'(sb32.pop_front());
    sb32.push_back(mk(15));
    rd32(4'h5, s);
    checks++; if (s !== exp_status32(m_ovf32, 1'b1)) begin failures++; $display("FAIL pushpop_status got=%h exp=%h", s, exp_status32(m_ovf32, 1'b1)); end
    for (int i = 0; i < 4; i++) begin
      head32(v);
      e = sb32.pop_front();
      checks++; if (v !== e) begin failures++; $display("FAIL pushpop_head%0d got=%h exp=%h", i, v, e); end
      wr32(4'hC, 32'h0);
    end
    push32(mk(21));
    @(negedge clk);
    b32.iChipSelect_n = 0; b32.iWrite_n = 0; b32.iAddress = 4'h4; b32.iData = 32'h4;
    b32.iCTValid = 1; b32.iCipherText = mk(22);
    @(negedge clk);
    b32.iChipSelect_n = 1; b32.iWrite_n = 1; b32.iCTValid = 0;
    sb32.delete();
    rd32(4'h5, s);
    checks++; if (s !== exp_status32(m_ovf32, 1'b1)) begin failures++; $display("FAIL fifo_clear got=%h exp=%h", s, exp_status32(m_ovf32, 1'b1)); end
  endtask

  task automatic test_irq();
    logic [31:0] s;
    logic [127:0] v, e;
    wr32(4'h6, 32'h1);
    rd32(4'h6, s);
    checks++; if (s !== 32'h1) begin failures++; $display("FAIL irq_en_read got=%h exp=1", s); end
    @(negedge clk);
    b32.iCTValid = 1; b32.iCipherText = mk(31);
    @(negedge clk);
    b32.iCTValid = 0;
    sb32.push_back(mk(31));
    checks++; if (b32.oIrq !== 1'b0) begin failures++; $display("FAIL irq_lag got=%b exp=0", b32.oIrq); end
    @(negedge clk);
    checks++; if (b32.oIrq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", b32.oIrq); end
    head32(v);
    e = sb32.pop_front();
    checks++; if (v !== e) begin failures++; $display("FAIL irq_head got=%h exp=%h", v, e); end
    wr32(4'hC, 32'h0);
    checks++; if (b32.oIrq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", b32.oIrq); end
    @(negedge clk);
    checks++; if (b32.oIrq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", b32.oIrq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    logic [127:0] v;
    int d0;
    b32.iCoreReady = 0;
    push32(mk(41));
    push32(mk(42));
    wr32(4'h4, 32'h1);
    head32(v);
    checks++; if (b32.oIrq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", b32.oIrq); end
    d0 = ld_data_cnt;
    @(negedge clk);
    rst_n = 0;
    b32.iCTValid = 1; b32.iCipherText = mk(43);
    #1;
    checks++; if ({b32.oData, b32.oIrq, b32.oLoadData, b32.oLoadKey} !== 35'h0) begin failures++; $display("FAIL mid_reset_outs got=%h exp=0", {b32.oData, b32.oIrq, b32.oLoadData, b32.oLoadKey}); end
    checks++; if (b32.oCoreData !== 128'h0) begin failures++; $display("FAIL mid_reset_core got=%h exp=0", b32.oCoreData); end
    @(negedge clk);
    b32.iCTValid = 0;
    @(negedge clk);
    rst_n = 1;
    sb32.delete();
    rd32(4'h5, s);
    checks++; if (s !== 32'h0) begin failures++; $display("FAIL post_reset_status got=%h exp=0", s); end
    b32.iCoreReady = 1;
    repeat (4) @(negedge clk);
    checks++; if (ld_data_cnt !== d0) begin failures++; $display("FAIL post_reset_load got=%0d exp=%0d", ld_data_cnt, d0); end
  endtask

  task automatic test_bus64();
    logic [63:0] d;
    logic [127:0] e;
    wr64(4'h0, 64'h0011_2233_4455_6677);
    wr64(4'h1, 64'h8899_AABB_CCDD_EEFF);
    wr64(4'h2, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (b64.oCoreData !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin failures++; $display("FAIL b64_block got=%h", b64.oCoreData); end
    rd64(4'h2, d);
    checks++; if (d !== 64'h0) begin failures++; $display("FAIL b64_word2 got=%h exp=0", d); end
    rd64(4'h0, d);
    checks++; if (d !== 64'h0011_2233_4455_6677) begin failures++; $display("FAIL b64_word0 got=%h exp=0011223344556677", d); end
    @(negedge clk);
    b64.iCTValid = 1; b64.iCipherText = mk(51);
    @(negedge clk);
    b64.iCTValid = 0;
    sb64.push_back(mk(51));
    e = sb64.pop_front();
    rd64(4'h8, d);
    checks++; if (d !== e[127:64]) begin failures++; $display("FAIL b64_head_hi got=%h exp=%h", d, e[127:64]); end
    rd64(4'h9, d);
    checks++; if (d !== e[63:0]) begin failures++; $display("FAIL b64_head_lo got=%h exp=%h", d, e[63:0]); end
    rd64(4'hA, d);
    checks++; if (d !== 64'h0) begin failures++; $display("FAIL b64_head_a got=%h exp=0", d); end
  endtask

  initial begin
    idle();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    repeat (2) @(negedge clk);
    test_key_load();
    test_pending_err();
    test_fifo_overflow();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    test_bus64();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
